// File: rtl/tx_frame_if.sv
// Bundle between the packet source / bench and tx_frame_scheduler: frame request,
// payload byte handshake and the serial modulator-facing outputs.
interface tx_frame_if #(
  parameter int FCW_W = 16
);
  logic             start;
  logic             mode_req;
  logic [FCW_W-1:0] fcw_req;
  logic [7:0]       payload_len;
  logic [7:0]       byte_data;
  logic             byte_valid;
  logic             byte_ready;
  logic             tx_bit;
  logic             tx_mode_sel;
  logic [FCW_W-1:0] tx_fcw;
  logic             tx_active;
  logic             busy;
  logic             done;
  logic             underrun;

  modport master (
    output start, mode_req, fcw_req, payload_len, byte_data, byte_valid,
    input  byte_ready, tx_bit, tx_mode_sel, tx_fcw, tx_active, busy, done, underrun
  );

  modport slave (
    input  start, mode_req, fcw_req, payload_len, byte_data, byte_valid,
    output byte_ready, tx_bit, tx_mode_sel, tx_fcw, tx_active, busy, done, underrun
  );
endinterface

// File: rtl/tx_frame_scheduler.sv
// Serialises one transmit frame (preamble, sync word, length, payload) at one bit
// per SYM_DIV clocks, holding modulator mode and FCW constant for the whole frame.
module tx_frame_scheduler #(
  parameter int          SYM_DIV      = 16,
  parameter int          PREAMBLE_LEN = 16,
  parameter logic [15:0] SYNC_WORD    = 16'hD391,
  parameter int          FCW_W        = 16
) (
  input  logic      clk,
  input  logic      rst,
  tx_frame_if.slave bus
);

  localparam int SYM_W    = (SYM_DIV > 2) ? $clog2(SYM_DIV) : 1;
  localparam int BIT_SPAN = (PREAMBLE_LEN > 16) ? PREAMBLE_LEN : 16;
  localparam int BIT_W    = $clog2(BIT_SPAN);

  localparam logic [SYM_W-1:0] SYM_LAST  = SYM_W'(SYM_DIV - 1);
  localparam logic [BIT_W-1:0] PRE_LAST  = BIT_W'(PREAMBLE_LEN - 1);
  localparam logic [BIT_W-1:0] SYNC_LAST = BIT_W'(15);
  localparam logic [BIT_W-1:0] BYTE_LAST = BIT_W'(7);

  typedef enum logic [2:0] {
    S_IDLE,
    S_PRE,
    S_SYNC,
    S_LEN,
    S_PAY,
    S_DONE
  } state_t;

  state_t           state_q, state_nxt;
  logic [SYM_W-1:0] sym_cnt;
  logic [BIT_W-1:0] bit_idx;
  logic [15:0]      shreg;
  logic [7:0]       pf_data;
  logic             pf_full;
  logic [7:0]       acc_cnt;
  logic [7:0]       sent_cnt;
  logic [7:0]       len_q;
  logic             mode_q;
  logic [FCW_W-1:0] fcw_q;
  logic             underrun_q;

  logic in_frame;
  logic sym_wrap;
  logic last_bit;
  logic byte_ready;
  logic xfer;
  logic load_sync;
  logic load_len;
  logic load_byte;
  logic ur_set;

  assign in_frame   = state_q inside {S_PRE, S_SYNC, S_LEN, S_PAY};
  assign sym_wrap   = (sym_cnt == SYM_LAST);
  assign byte_ready = in_frame && !pf_full && (acc_cnt < len_q);
  assign xfer       = byte_ready && bus.byte_valid;

  always_comb begin
    last_bit = 1'b0;
    case (state_q)
      S_PRE:        last_bit = (bit_idx == PRE_LAST);
      S_SYNC:       last_bit = (bit_idx == SYNC_LAST);
      S_LEN, S_PAY: last_bit = (bit_idx == BYTE_LAST);
      default:      last_bit = 1'b0;
    endcase
  end

  // Next-state: phase changes only at the end of a phase's last bit period
  always_comb begin
    state_nxt = state_q;
    load_sync = 1'b0;
    load_len  = 1'b0;
    load_byte = 1'b0;
    ur_set    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (bus.start) state_nxt = S_PRE;
      end
      S_PRE: begin
        if (sym_wrap && last_bit) begin
          state_nxt = S_SYNC;
          load_sync = 1'b1;
        end
      end
      S_SYNC: begin
        if (sym_wrap && last_bit) begin
          state_nxt = S_LEN;
          load_len  = 1'b1;
        end
      end
      S_LEN, S_PAY: begin
        if (sym_wrap && last_bit) begin
          if (sent_cnt == len_q) begin
            state_nxt = S_DONE;
          end else if (pf_full) begin
            state_nxt = S_PAY;
            load_byte = 1'b1;
          end else begin
            state_nxt = S_IDLE;
            ur_set    = 1'b1;
          end
        end
      end
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Control state; counters restart every time the scheduler sits in IDLE
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= S_IDLE;
      sym_cnt    <= '0;
      bit_idx    <= '0;
      acc_cnt    <= '0;
      sent_cnt   <= '0;
      pf_full    <= 1'b0;
      underrun_q <= 1'b0;
      mode_q     <= 1'b0;
      fcw_q      <= '0;
      len_q      <= '0;
    end else begin
      state_q    <= state_nxt;
      underrun_q <= ur_set;
      if (state_q == S_IDLE) begin
        sym_cnt  <= '0;
        bit_idx  <= '0;
        acc_cnt  <= '0;
        sent_cnt <= '0;
        pf_full  <= 1'b0;
        if (bus.start) begin
          mode_q <= bus.mode_req;
          fcw_q  <= bus.fcw_req;
          len_q  <= bus.payload_len;
        end
      end else if (in_frame) begin
        sym_cnt <= sym_wrap ? '0 : sym_cnt + 1'b1;
        if (sym_wrap) bit_idx <= last_bit ? '0 : bit_idx + 1'b1;
        if (xfer) begin
          pf_full <= 1'b1;
          acc_cnt <= acc_cnt + 1'b1;
        end
        if (load_byte) begin
          pf_full  <= 1'b0;
          sent_cnt <= sent_cnt + 1'b1;
        end
      end
    end
  end

  // Shift/prefetch data: loads override the per-symbol shift at phase boundaries
  always_ff @(posedge clk) begin
    if (in_frame && sym_wrap) shreg <= {shreg[14:0], 1'b0};
    if (load_sync)            shreg <= SYNC_WORD;
    if (load_len)             shreg <= {len_q, 8'h00};
    if (load_byte)            shreg <= {pf_data, 8'h00};
    if (xfer)                 pf_data <= bus.byte_data;
  end

  assign bus.byte_ready  = byte_ready;
  assign bus.tx_bit      = (state_q == S_PRE) ? ~bit_idx[0] :
                           (state_q inside {S_SYNC, S_LEN, S_PAY}) ? shreg[15] : 1'b0;
  assign bus.tx_mode_sel = mode_q;
  assign bus.tx_fcw      = fcw_q;
  assign bus.tx_active   = in_frame;
  assign bus.busy        = (state_q != S_IDLE);
  assign bus.done        = (state_q == S_DONE);
  assign bus.underrun    = underrun_q;

endmodule

// File: tb/tb_tx_frame_scheduler.sv
// Scoreboard bench for tx_frame_scheduler: stimulus queues expected per-cycle bits and
// end events; a negedge monitor compares everything the DUTs present.
module tb_tx_frame_scheduler;

  localparam int          PRE_LEN = 8;
  localparam logic [15:0] SYNC    = 16'hD391;
  localparam int          EV_DONE = 1;
  localparam int          EV_UR   = 2;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  tx_frame_if #(.FCW_W(16)) bus_a ();
  tx_frame_if #(.FCW_W(16)) bus_b ();

  tx_frame_scheduler #(.SYM_DIV(4), .PREAMBLE_LEN(PRE_LEN), .SYNC_WORD(16'hD391), .FCW_W(16))
    dut_a (.clk(clk), .rst(rst), .bus(bus_a));
  tx_frame_scheduler #(.SYM_DIV(16), .PREAMBLE_LEN(PRE_LEN), .SYNC_WORD(16'hD391), .FCW_W(16))
    dut_b (.clk(clk), .rst(rst), .bus(bus_b));

  bit         exp_q  [2][$];
  int         ev_q   [2][$];
  logic [7:0] src_q  [2][$];
  string      snap_q [2][$];
  string      fail_q [$];
  logic       exp_mode [2];
  logic [15:0] exp_fcw [2];
  bit         no_ready [2];
  bit         bp_mode  [2];
  bit         prev_act [2];
  bit         prev_done[2];
  int         n_chk = 0;
  int         n_fail = 0;

  task automatic chk(input string nm, input int ln, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s lane%0d: got 0x%0h, expected 0x%0h (t=%0t)", nm, ln, got, exp, $time);
    end
  endtask

  task automatic mon_lane(input int ln, input logic act, input logic b, input logic md,
                          input logic [15:0] fc, input logic bsy, input logic dn,
                          input logic ur, input logic rdy);
    int e;
    if (snap_q[ln].size() > 0)
      chk(snap_q[ln].pop_front(), ln, {9'd0, b, md, fc, act, bsy, dn, ur, rdy}, 32'd0);
    if (dn || ur) begin
      if (ev_q[ln].size() == 0) begin
        chk("unexpected_end", ln, {30'd0, dn, ur}, 32'd0);
      end else begin
        e = ev_q[ln].pop_front();
        chk("end_event", ln, {30'd0, dn, ur}, (e == EV_DONE) ? 32'd2 : 32'd1);
        chk("bits_left", ln, exp_q[ln].size(), 32'd0);
      end
      if (dn) chk("done_after_active", ln, {29'd0, prev_act[ln], act, bsy}, 32'd5);
      if (ur) chk("underrun_idle", ln, {29'd0, act, b, bsy}, 32'd0);
    end
    if (prev_done[ln]) chk("busy_after_done", ln, {31'd0, bsy}, 32'd0);
    if (act) begin
      if (exp_q[ln].size() == 0) chk("extra_active_cycle", ln, 32'd1, 32'd0);
      else                       chk("tx_bit", ln, {31'd0, b}, {31'd0, exp_q[ln].pop_front()});
      chk("tx_mode_sel", ln, {31'd0, md}, {31'd0, exp_mode[ln]});
      chk("tx_fcw", ln, {16'd0, fc}, {16'd0, exp_fcw[ln]});
    end
    if (no_ready[ln]) chk("byte_ready_zero_len", ln, {31'd0, rdy}, 32'd0);
    prev_act[ln]  = act;
    prev_done[ln] = dn;
  endtask

  // Monitor: the only process that compares and counts
  always @(negedge clk) begin
    while (fail_q.size() > 0) chk(fail_q.pop_front(), 0, 32'd1, 32'd0);
    mon_lane(0, bus_a.tx_active, bus_a.tx_bit, bus_a.tx_mode_sel, bus_a.tx_fcw,
             bus_a.busy, bus_a.done, bus_a.underrun, bus_a.byte_ready);
    mon_lane(1, bus_b.tx_active, bus_b.tx_bit, bus_b.tx_mode_sel, bus_b.tx_fcw,
             bus_b.busy, bus_b.done, bus_b.underrun, bus_b.byte_ready);
  end

  // Byte sources: present the head of src_q, pop it after an observed transfer
  initial begin : feeder_a
    bit x;
    int cyc = 0;
    bus_a.byte_valid = 1'b0;
    bus_a.byte_data  = 8'h00;
    forever begin
      @(negedge clk);
      x = bus_a.byte_valid && bus_a.byte_ready;
      @(posedge clk);
      #1;
      if (x && src_q[0].size() > 0) void'(src_q[0].pop_front());
      cyc++;
      bus_a.byte_valid = (src_q[0].size() > 0) && (!bp_mode[0] || (cyc % 3 == 0));
      bus_a.byte_data  = (src_q[0].size() > 0) ? src_q[0][0] : 8'h00;
    end
  end

  initial begin : feeder_b
    bit x;
    int cyc = 0;
    bus_b.byte_valid = 1'b0;
    bus_b.byte_data  = 8'h00;
    forever begin
      @(negedge clk);
      x = bus_b.byte_valid && bus_b.byte_ready;
      @(posedge clk);
      #1;
      if (x && src_q[1].size() > 0) void'(src_q[1].pop_front());
      cyc++;
      bus_b.byte_valid = (src_q[1].size() > 0) && (!bp_mode[1] || (cyc % 3 == 0));
      bus_b.byte_data  = (src_q[1].size() > 0) ? src_q[1][0] : 8'h00;
    end
  end

  task automatic push_bit(input int ln, input int sd, input bit b);
    repeat (sd) exp_q[ln].push_back(b);
  endtask

  task automatic push_frame(input int ln, input int sd, input logic [7:0] len,
                            input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2,
                            input int nsend, input int ev);
    logic [7:0] bs [3];
    bs = '{b0, b1, b2};
    for (int i = 0; i < PRE_LEN; i++) push_bit(ln, sd, (i % 2) == 0);
    for (int i = 15; i >= 0; i--)     push_bit(ln, sd, SYNC[i]);
    for (int i = 7; i >= 0; i--)      push_bit(ln, sd, len[i]);
    for (int k = 0; k < nsend; k++) begin
      src_q[ln].push_back(bs[k]);
      for (int i = 7; i >= 0; i--) push_bit(ln, sd, bs[k][i]);
    end
    ev_q[ln].push_back(ev);
  endtask

  task automatic start_frame(input int ln, input logic md, input logic [15:0] fc, input logic [7:0] len);
    @(posedge clk);
    #1;
    exp_mode[ln] = md;
    exp_fcw[ln]  = fc;
    if (ln == 0) begin
      bus_a.mode_req = md; bus_a.fcw_req = fc; bus_a.payload_len = len; bus_a.start = 1'b1;
    end else begin
      bus_b.mode_req = md; bus_b.fcw_req = fc; bus_b.payload_len = len; bus_b.start = 1'b1;
    end
    @(posedge clk);
    #1;
    bus_a.start = 1'b0;
    bus_b.start = 1'b0;
  endtask

  task automatic wait_frame(input int ln, input int maxc);
    int c = 0;
    while (ev_q[ln].size() > 0 && c < maxc) begin
      @(posedge clk);
      c++;
    end
    if (ev_q[ln].size() > 0) begin
      fail_q.push_back("frame_timeout");
      ev_q[ln].delete();
      exp_q[ln].delete();
      src_q[ln].delete();
    end
    repeat (2) @(posedge clk);
    #1;
  endtask

  initial begin : stimulus
    logic [47:0] nv;
    bus_a.start = 1'b0; bus_a.mode_req = 1'b0; bus_a.fcw_req = 16'h0; bus_a.payload_len = 8'h0;
    bus_b.start = 1'b0; bus_b.mode_req = 1'b0; bus_b.fcw_req = 16'h0; bus_b.payload_len = 8'h0;
    for (int l = 0; l < 2; l++) begin
      exp_mode[l] = 1'b0; exp_fcw[l] = 16'h0; no_ready[l] = 1'b0; bp_mode[l] = 1'b0;
      prev_act[l] = 1'b0; prev_done[l] = 1'b0;
    end

    repeat (3) @(posedge clk);
    #1;
    snap_q[0].push_back("reset_state");
    snap_q[1].push_back("reset_state");
    @(posedge clk);
    #1;
    rst = 1'b1;
    repeat (2) @(posedge clk);

    // Nominal: hand-written bit sequence, 48 bits x 4 cycles = 192 active cycles
    nv = 48'b10101010_1101001110010001_00000010_00111100_10100101;
    src_q[0].push_back(8'h3C);
    src_q[0].push_back(8'hA5);
    for (int i = 47; i >= 0; i--) push_bit(0, 4, nv[i]);
    ev_q[0].push_back(EV_DONE);
    start_frame(0, 1'b0, 16'h0123, 8'd2);
    wait_frame(0, 400);

    // Zero length: preamble + sync + 0x00 only, byte_ready must stay low
    no_ready[0] = 1'b1;
    push_frame(0, 4, 8'd0, 8'h00, 8'h00, 8'h00, 0, EV_DONE);
    start_frame(0, 1'b1, 16'h00FF, 8'd0);
    wait_frame(0, 400);
    no_ready[0] = 1'b0;

    // Underrun: three bytes announced, two supplied
    push_frame(0, 4, 8'd3, 8'h11, 8'hEE, 8'h00, 2, EV_UR);
    start_frame(0, 1'b0, 16'h0100, 8'd3);
    wait_frame(0, 400);

    // Config hold: a start with different config mid-frame must be ignored
    push_frame(0, 4, 8'd1, 8'h96, 8'h00, 8'h00, 1, EV_DONE);
    start_frame(0, 1'b1, 16'h0400, 8'd1);
    repeat (50) @(posedge clk);
    #1;
    bus_a.mode_req = 1'b0; bus_a.fcw_req = 16'h1234; bus_a.payload_len = 8'd9; bus_a.start = 1'b1;
    @(posedge clk);
    #1;
    bus_a.start = 1'b0;
    wait_frame(0, 400);

    // Reset during SYNC, then a fresh full frame
    push_frame(0, 4, 8'd1, 8'h5A, 8'h00, 8'h00, 1, EV_DONE);
    start_frame(0, 1'b1, 16'h0777, 8'd1);
    repeat (40) @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk);
    #1;
    exp_q[0].delete();
    ev_q[0].delete();
    src_q[0].delete();
    rst = 1'b1;
    snap_q[0].push_back("reset_midframe");
    snap_q[1].push_back("reset_midframe");
    repeat (2) @(posedge clk);
    push_frame(0, 4, 8'd2, 8'hF0, 8'h0F, 8'h00, 2, EV_DONE);
    start_frame(0, 1'b0, 16'h0ABC, 8'd2);
    wait_frame(0, 400);

    // Backpressure on the SYM_DIV=16 lane: valid one cycle in three
    bp_mode[1] = 1'b1;
    push_frame(1, 16, 8'd3, 8'h81, 8'h7E, 8'hC3, 3, EV_DONE);
    start_frame(1, 1'b0, 16'h2000, 8'd3);
    wait_frame(1, 3000);

    if (exp_q[0].size() != 0 || exp_q[1].size() != 0) fail_q.push_back("bits_never_sent");
    if (src_q[0].size() != 0 || src_q[1].size() != 0) fail_q.push_back("bytes_never_taken");
    repeat (2) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin : watchdog
    #300000;
    $display("FAIL watchdog: simulation did not finish, expected completion before %0t", $time);
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/tx_frame_scheduler.md
Name: tx_frame_scheduler

Overview:
Sequences one transmit frame into the modulator/NCO datapath: preamble, sync word, length byte, then payload bytes pulled from an upstream byte source. It emits one bit per symbol period on tx_bit, which drives the modulator's data input. It latches and holds the modulation mode and frequency control word for the whole frame, so the modulator configuration never changes mid-frame. It sits between the packet source and the modulator_config/nco pair inside data_transmit.

Parameters:
SYM_DIV, 16, clock cycles per transmitted bit (≥2)
PREAMBLE_LEN, 16, preamble length in bits (≥1), pattern 1,0,1,0,…
SYNC_WORD, 16'hD391, 16-bit sync word, sent MSB first
FCW_W, 16, frequency control word width

Ports:
clk  in  1  system clock
rst  in  1  reset, synchronous, active-low
start  in  1  request a frame; sampled only in IDLE
mode_req  in  1  modulation mode for the frame (to mode_sel)
fcw_req  in  FCW_W  frequency control word for the frame
payload_len  in  8  payload byte count, 0–255, latched at start
byte_data  in  8  payload byte
byte_valid  in  1  byte_data valid
byte_ready  out  1  scheduler accepts byte_data this cycle
tx_bit  out  1  serial bit to the modulator data input
tx_mode_sel  out  1  latched mode to the modulator
tx_fcw  out  FCW_W  latched FCW to the NCO/modulator
tx_active  out  1  high while frame bits are on tx_bit
busy  out  1  high in any state other than IDLE
done  out  1  one-cycle pulse when a frame completes normally
underrun  out  1  one-cycle pulse when a frame is aborted for lack of data

Behaviour:
- Reset (rst=0 at a clk edge): state=IDLE.
  - Outputs: tx_bit=0, tx_mode_sel=0, tx_fcw=0, tx_active=0, busy=0, done=0, underrun=0, byte_ready=0.
  - Internal state: symbol counter, bit counter and byte counter cleared; prefetch buffer emptied.
  - Applies mid-frame too: the cycle after rst is sampled low, all outputs hold reset values.
- Clocking: all state changes on the clk rising edge.
- States: IDLE → PRE → SYNC → LEN → PAY → DONE → IDLE.
- IDLE:
  - start=1 at edge N: latch mode_req→tx_mode_sel, fcw_req→tx_fcw, and payload_len.
  - In cycle N+1: state=PRE, tx_active=1, tx_bit=1 (first preamble bit), symbol counter=0.
  - start outside IDLE is ignored.
  - tx_mode_sel and tx_fcw change only on a start accepted in IDLE; otherwise they hold.
- Symbol timing:
  - The symbol counter runs 0..SYM_DIV-1 and wraps.
  - tx_bit changes only on wrap, so every bit is held exactly SYM_DIV cycles.
- PRE: PREAMBLE_LEN bits, alternating starting with 1, then SYNC.
- SYNC: SYNC_WORD, 16 bits MSB first, then LEN.
- LEN: latched payload_len, 8 bits MSB first.
  - After LEN, go to PAY if length > 0, else DONE.
- PAY: bytes sent MSB first, in order of acceptance. Bits sent exactly match accepted bytes.
- Prefetch buffer (one byte):
  - byte_ready = busy and state in {PRE, SYNC, LEN, PAY}, buffer empty, and bytes accepted < latched length.
  - A transfer occurs when byte_valid and byte_ready are both 1 in the same cycle; the byte is stored in the buffer.
  - At each byte boundary in PAY (including entry from LEN), the buffer moves into the shift register and the buffer is freed in the same cycle.
  - byte_ready may then rise the next cycle.
- Underrun:
  - Condition: at a PAY byte boundary the buffer is empty.
  - Next cycle: underrun=1 for one cycle, tx_active=0, tx_bit=0, state=IDLE.
  - No done pulse; the partial frame is abandoned; buffer and counters are cleared.
- DONE:
  - Entered when the last payload bit period (or the last LEN bit period, if length=0) ends.
  - One cycle in DONE: done=1, tx_active=0, tx_bit=0, busy=1. Then IDLE.
  - busy drops to 0 the cycle after done.
  - start is not accepted in DONE; it is first accepted in the following IDLE cycle.
- Frame length in tx_active cycles: (PREAMBLE_LEN + 16 + 8 + 8×payload_len) × SYM_DIV.

Test Plan:
- Nominal frame.
  - Setup: SYM_DIV=4, PREAMBLE_LEN=8, start with payload_len=2, bytes 0x3C and 0xA5 presented with byte_valid held high.
  - tx_active high for exactly 192 cycles.
  - tx_bit sequence: 10101010, 1101001110010001, 00000010, 00111100, 10100101, each bit held 4 cycles.
  - done pulses once, in the cycle after tx_active falls.
- Zero length: payload_len=0 → frame is preamble+sync+0x00 (32×SYM_DIV cycles); byte_ready never asserts; done pulses.
- Underrun: payload_len=3, only 2 bytes supplied → after the second byte's last bit, underrun=1 for one cycle, tx_active=0, done never pulses, busy=0 on the next cycle.
- Config hold: start with mode_req=1, fcw_req=0x0400, then change mode_req/fcw_req and pulse start mid-frame → tx_mode_sel=1, tx_fcw=0x0400 for the whole frame; the second start is ignored.
- Reset mid-frame: drive rst=0 for one cycle during SYNC → next cycle all outputs 0 and state IDLE; a new start produces a full, correct frame.
- Backpressure: byte_valid toggling 1-of-3 cycles with SYM_DIV=16 → no underrun; payload bits match accepted bytes in order.
